// File: rtl/conv_window_sequencer.sv
// Operand sequencer for the FP multiply-accumulate PE: latches a KxK window and kernel,
// streams element pairs into the PE one per clock, captures the dot product and hands it off.
module conv_window_sequencer #(
  parameter int DATA_WIDTH  = 32,
  parameter int KERNEL_SIZE = 5
) (
  input  logic                                              clk,
  input  logic                                              reset,
  input  logic                                              start,
  input  logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0]      window,
  input  logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0]      kernel,
  output logic                                              busy,
  output logic [DATA_WIDTH-1:0]                             pe_a,
  output logic [DATA_WIDTH-1:0]                             pe_b,
  output logic                                              pe_clear,
  input  logic [DATA_WIDTH-1:0]                             pe_result,
  output logic [DATA_WIDTH-1:0]                             out_data,
  output logic                                              out_valid,
  input  logic                                              out_ready
);

  localparam int unsigned N     = KERNEL_SIZE * KERNEL_SIZE;
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  typedef enum logic [1:0] {
    IDLE,
    FEED,
    CAPTURE,
    OUTPUT
  } state_t;

  state_t state, state_next;

  logic [IDX_W-1:0]      idx;
  logic [DATA_WIDTH-1:0] window_buf [N];
  logic [DATA_WIDTH-1:0] kernel_buf [N];
  logic                  accept;
  logic                  handshake;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    handshake  = 1'b0;
    pe_a       = '0;
    pe_b       = '0;
    case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = FEED;
        end
      end
      FEED: begin
        pe_a = window_buf[idx];
        pe_b = kernel_buf[idx];
        if (idx == LAST_IDX) state_next = CAPTURE;
      end
      CAPTURE: state_next = OUTPUT;
      OUTPUT: begin
        if (out_valid && out_ready) begin
          handshake  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // Operand buffers carry no reset: they are only ever read after a start latches them.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int unsigned i = 0; i < N; i++) begin
        window_buf[i] <= window[i*DATA_WIDTH +: DATA_WIDTH];
        kernel_buf[i] <= kernel[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx       <= '0;
      pe_clear  <= 1'b1;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      if (accept) begin
        idx      <= '0;
        pe_clear <= 1'b0;
      end
      if (state == FEED) begin
        idx <= (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
      end
      if (state == CAPTURE) begin
        out_data  <= pe_result;
        out_valid <= 1'b1;
      end
      if (handshake) begin
        out_valid <= 1'b0;
        pe_clear  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_conv_window_sequencer.sv
// Directed bench for conv_window_sequencer with a behavioural FP MAC standing in for the PE.
module tb_conv_window_sequencer;

  localparam int DW = 32;
  localparam int K  = 5;
  localparam int N  = K * K;

  localparam logic [31:0] F_P1  = 32'h3F800000;
  localparam logic [31:0] F_M1  = 32'hBF800000;
  localparam logic [31:0] F_2   = 32'h40000000;
  localparam logic [31:0] F_3   = 32'h40400000;
  localparam logic [31:0] F_6   = 32'h40C00000;
  localparam logic [31:0] F_25  = 32'h41C80000;
  localparam logic [31:0] F_50  = 32'h42480000;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [N*DW-1:0]   window;
  logic [N*DW-1:0]   kernel;
  logic              busy;
  logic [DW-1:0]     pe_a;
  logic [DW-1:0]     pe_b;
  logic              pe_clear;
  logic [DW-1:0]     pe_result;
  logic [DW-1:0]     out_data;
  logic              out_valid;
  logic              out_ready;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  conv_window_sequencer #(.DATA_WIDTH(DW), .KERNEL_SIZE(K)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .window    (window),
    .kernel    (kernel),
    .busy      (busy),
    .pe_a      (pe_a),
    .pe_b      (pe_b),
    .pe_clear  (pe_clear),
    .pe_result (pe_result),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  function automatic real sp2real(input logic [31:0] b);
    int  e;
    real m;
    e = int'(b[30:23]);
    if (e == 0) return 0.0;
    m = 1.0 + real'(b[22:0]) / 8388608.0;
    for (int i = 127; i < e; i++) m = m * 2.0;
    for (int i = e; i < 127; i++) m = m / 2.0;
    return b[31] ? -m : m;
  endfunction

  function automatic logic [31:0] real2sp(input real r);
    logic [63:0] d;
    logic [7:0]  e8;
    if (r == 0.0) return 32'h0;
    d  = $realtobits(r);
    e8 = 8'(int'(d[62:52]) - 896);
    return {d[63], e8, d[51:29]};
  endfunction

  // Behavioural PE: asynchronous clear, accumulates a*b each rising edge.
  real acc;
  always @(posedge clk or posedge pe_clear) begin
    if (pe_clear) acc <= 0.0;
    else          acc <= acc + sp2real(pe_a) * sp2real(pe_b);
  end
  always_comb pe_result = real2sp(acc);

  function automatic logic [N*DW-1:0] fill(input logic [31:0] v);
    logic [N*DW-1:0] r;
    for (int i = 0; i < N; i++) r[i*DW +: DW] = v;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Enter at a negedge with the DUT idle; returns at the negedge where out_valid is seen.
  task automatic run_window(input logic [N*DW-1:0] w, input logic [N*DW-1:0] k,
                            input logic [31:0] exp, input bit order, input string tag);
    int cycles;
    window = w;
    kernel = k;
    start  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start  = 1'b0;
    window = ~w;
    kernel = ~k;
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    chk({tag, "_clear_low"}, 32'(pe_clear), 32'd0);
    cycles = 0;
    while (!out_valid && cycles < 60) begin
      if (order && cycles < N) begin
        chk($sformatf("%s_pe_a%0d", tag, cycles), pe_a, w[cycles*DW +: DW]);
        chk($sformatf("%s_pe_b%0d", tag, cycles), pe_b, k[cycles*DW +: DW]);
      end
      if (order && cycles == N) chk({tag, "_capture_a0"}, pe_a, 32'h0);
      @(negedge clk);
      cycles++;
    end
    chk({tag, "_latency"}, 32'(cycles), 32'(N + 1));
    chk({tag, "_data"}, out_data, exp);
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
    chk({tag, "_idle"}, 32'(busy), 32'd0);
    chk({tag, "_clear_high"}, 32'(pe_clear), 32'd1);
  endtask

  logic [N*DW-1:0] w_v, k_v;

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    out_ready = 1'b0;
    window    = '0;
    kernel    = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_clear", 32'(pe_clear), 32'd1);
    chk("rst_pe_a", pe_a, 32'h0);
    chk("rst_pe_b", pe_b, 32'h0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", out_data, 32'h0);
    reset = 1'b0;
    @(negedge clk);

    // all ones
    run_window(fill(F_P1), fill(F_P1), F_25, 1'b0, "ones");
    handshake("ones");
    @(negedge clk);

    // single nonzero element at index 12
    w_v = '0; k_v = '0;
    w_v[12*DW +: DW] = F_3;
    k_v[12*DW +: DW] = F_2;
    run_window(w_v, k_v, F_6, 1'b0, "sparse");
    handshake("sparse");
    @(negedge clk);

    // alternating kernel, with per-cycle operand order check
    k_v = '0;
    for (int i = 0; i < N; i++) k_v[i*DW +: DW] = (i % 2 == 0) ? F_P1 : F_M1;
    run_window(fill(F_P1), k_v, F_P1, 1'b1, "alt");
    handshake("alt");
    @(negedge clk);

    // back-pressure with start pulsed during the stall
    run_window(fill(F_P1), fill(F_P1), F_25, 1'b0, "stall");
    for (int c = 0; c < 10; c++) begin
      chk($sformatf("stall_valid%0d", c), 32'(out_valid), 32'd1);
      chk($sformatf("stall_data%0d", c), out_data, F_25);
      start  = (c == 3);
      window = fill(F_3);
      @(negedge clk);
    end
    start = 1'b0;
    chk("stall_valid_end", 32'(out_valid), 32'd1);
    handshake("stall");
    @(negedge clk);
    chk("stall_no_restart", 32'(busy), 32'd0);

    // back-to-back: second start lands on the edge right after acceptance
    run_window(fill(F_P1), fill(F_P1), F_25, 1'b0, "b2b1");
    handshake("b2b1");
    run_window(fill(F_2), fill(F_P1), F_50, 1'b0, "b2b2");
    handshake("b2b2");
    @(negedge clk);

    // reset asserted at idx=10
    window = fill(F_P1);
    kernel = fill(F_P1);
    start  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    chk("mid_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    chk("mid_rst_clear", 32'(pe_clear), 32'd1);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_pe_a", pe_a, 32'h0);
    chk("mid_rst_pe_b", pe_b, 32'h0);
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_data", out_data, 32'h0);
    chk("mid_rst_pe_result", pe_result, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk($sformatf("post_rst_valid%0d", c), 32'(out_valid), 32'd0);
    end
    run_window(fill(F_P1), fill(F_P1), F_25, 1'b0, "after_rst");
    handshake("after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
